// File: rtl/check_ram_nport.sv
// rtl/check_ram_nport.sv - set-associative translation RAM with N-port parallel set scan and hit/protection check
module check_ram_nport #(
    parameter int ADDR_WIDTH     = 32,
    parameter int PAGE_SIZE      = 4096,
    parameter int SET_WIDTH      = 5,
    parameter int OFFSET_WIDTH   = 4,
    parameter int N_PORTS        = 2,
    parameter int MULTIHIT_CHECK = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_valid,
    output logic                              start_ready,
    input  logic [ADDR_WIDTH-1:0]             in_addr,
    input  logic                              rw_type,
    input  logic [SET_WIDTH-1:0]              set_idx,
    input  logic                              ram_we,
    input  logic [SET_WIDTH+OFFSET_WIDTH-1:0] ram_waddr,
    input  logic [31:0]                       ram_wdata,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              hit,
    output logic                              multi_hit,
    output logic [SET_WIDTH+OFFSET_WIDTH-1:0] hit_addr,
    output logic                              master,
    output logic                              prot
);

    localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
    localparam int VPN_W      = ADDR_WIDTH - IGNORE_LSB;
    localparam int AW         = SET_WIDTH + OFFSET_WIDTH;
    localparam int DEPTH      = 2 ** OFFSET_WIDTH;
    localparam int S          = DEPTH / N_PORTS;
    localparam int K_W        = (S > 1) ? $clog2(S) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Storage: the RAM array and its registered read ports carry no reset
    logic [31:0]             r_mem     [2**AW];
    logic [31:0]             r_rd_data [N_PORTS];

    // Search context
    logic [1:0]              r_state;
    logic [K_W-1:0]          r_k;
    logic [VPN_W-1:0]        r_vpn_q;
    logic                    r_rw_q;
    logic [SET_WIDTH-1:0]    r_set_q;

    // Read pipeline tag: which offsets the data in r_rd_data belongs to
    logic                    r_rd_vld;
    logic [OFFSET_WIDTH-1:0] r_rd_base;

    // Hit records
    logic [1:0]              r_hit_cnt;
    logic [OFFSET_WIDTH-1:0] r_hit_off;
    logic                    r_hit_master;
    logic                    r_hit_prot;

    logic [OFFSET_WIDTH-1:0] w_base;
    logic [AW-1:0]           w_raddr [N_PORTS];
    logic                    w_any;
    logic [1:0]              w_cyc_cnt;
    logic [OFFSET_WIDTH-1:0] w_first_off;
    logic                    w_first_master;
    logic                    w_first_wr;
    logic                    w_first_rd;
    logic                    w_cmp;
    logic [2:0]              w_sum;
    logic [1:0]              w_new_cnt;
    logic                    w_stop_early;
    logic                    w_done;
    logic                    w_unused;

    assign w_base = OFFSET_WIDTH'(int'(r_k) * N_PORTS);

    // Port p reads offset k*N_PORTS+p of the latched set
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_raddr[p] = {r_set_q, w_base + OFFSET_WIDTH'(p)};
        end
    end

    // Single write port plus N read ports; non-blocking update gives read-first behaviour
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            r_mem[ram_waddr] <= ram_wdata;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            r_rd_data[p] <= r_mem[w_raddr[p]];
        end
    end

    // Tag the read data so the compare cycle knows whether and where it was read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_vld  <= 1'b0;
            r_rd_base <= '0;
        end else begin
            r_rd_vld  <= (r_state == ST_SEARCH);
            r_rd_base <= w_base;
        end
    end

    // Compare every port; lowest port index wins the first-hit slot, count saturates at 2
    always_comb begin
        w_any          = 1'b0;
        w_cyc_cnt      = 2'd0;
        w_first_off    = '0;
        w_first_master = 1'b0;
        w_first_wr     = 1'b0;
        w_first_rd     = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (r_rd_data[p][0] && (r_rd_data[p][4 +: VPN_W] == r_vpn_q)) begin
                if (!w_any) begin
                    w_first_off    = r_rd_base + OFFSET_WIDTH'(p);
                    w_first_master = r_rd_data[p][3];
                    w_first_wr     = r_rd_data[p][2];
                    w_first_rd     = r_rd_data[p][1];
                end
                w_any = 1'b1;
                if (w_cyc_cnt != 2'd2) begin
                    w_cyc_cnt = w_cyc_cnt + 2'd1;
                end
            end
        end
    end

    assign w_cmp        = r_rd_vld && ((r_state == ST_SEARCH) || (r_state == ST_DRAIN));
    assign w_sum        = {1'b0, r_hit_cnt} + {1'b0, w_cyc_cnt};
    assign w_new_cnt    = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_stop_early = (MULTIHIT_CHECK == 0) && w_cmp && w_any;

    // Control FSM: accept, scan S steps, one drain compare, hold result until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_vpn_q <= '0;
            r_rw_q  <= 1'b0;
            r_set_q <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_vpn_q <= in_addr[ADDR_WIDTH-1:IGNORE_LSB];
                        r_rw_q  <= rw_type;
                        r_set_q <= set_idx;
                        r_k     <= '0;
                        r_state <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    r_k <= r_k + 1'b1;
                    if (w_stop_early) begin
                        r_state <= ST_DONE;
                    end else if (r_k == K_W'(S - 1)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Hit records: cleared on accept, first hit captured once, count accumulates per compare
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt    <= 2'd0;
            r_hit_off    <= '0;
            r_hit_master <= 1'b0;
            r_hit_prot   <= 1'b0;
        end else if ((r_state == ST_IDLE) && start_valid) begin
            r_hit_cnt    <= 2'd0;
            r_hit_off    <= '0;
            r_hit_master <= 1'b0;
            r_hit_prot   <= 1'b0;
        end else if (w_cmp) begin
            r_hit_cnt <= w_new_cnt;
            if ((r_hit_cnt == 2'd0) && w_any) begin
                r_hit_off    <= w_first_off;
                r_hit_master <= w_first_master;
                r_hit_prot   <= r_rw_q ? ~w_first_wr : ~w_first_rd;
            end
        end
    end

    assign w_done      = (r_state == ST_DONE);
    assign start_ready = (r_state == ST_IDLE);
    assign out_valid   = w_done;
    assign hit         = w_done && (r_hit_cnt != 2'd0);
    assign multi_hit   = w_done && (r_hit_cnt == 2'd2);
    assign hit_addr    = (w_done && (r_hit_cnt != 2'd0)) ? {r_set_q, r_hit_off} : '0;
    assign master      = w_done && r_hit_master;
    assign prot        = w_done && r_hit_prot;

    // Page-offset bits and spare entry bits take no part in the lookup
    always_comb begin
        w_unused = ^in_addr[IGNORE_LSB-1:0];
        for (int p = 0; p < N_PORTS; p++) begin
            w_unused = w_unused ^ (^r_rd_data[p]);
        end
    end

endmodule

// File: tb/tb_check_ram_nport.sv
// tb/tb_check_ram_nport.sv - randomized and directed bench for check_ram_nport (full-scan and first-hit builds)
module tb_check_ram_nport;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_valid;
    logic [31:0] in_addr;
    logic        rw_type;
    logic [4:0]  set_idx;
    logic        ram_we;
    logic [8:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic        out_ready;

    logic        f_start_ready, f_out_valid, f_hit, f_multi_hit, f_master, f_prot;
    logic [8:0]  f_hit_addr;
    logic        q_start_ready, q_out_valid, q_hit, q_multi_hit, q_master, q_prot;
    logic [8:0]  q_hit_addr;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [512];

    int e_hit, e_multi, e_addr, e_master, e_prot;
    int e_qhit, e_qmulti, e_qaddr, e_qmaster, e_qprot, e_qlat;

    always #5 clk_i = ~clk_i;

    check_ram_nport #(.MULTIHIT_CHECK(1)) dut_full (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .start_valid(start_valid), .start_ready(f_start_ready),
        .in_addr(in_addr), .rw_type(rw_type), .set_idx(set_idx),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .out_valid(f_out_valid), .out_ready(out_ready),
        .hit(f_hit), .multi_hit(f_multi_hit), .hit_addr(f_hit_addr),
        .master(f_master), .prot(f_prot)
    );

    check_ram_nport #(.MULTIHIT_CHECK(0)) dut_fast (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .start_valid(start_valid), .start_ready(q_start_ready),
        .in_addr(in_addr), .rw_type(rw_type), .set_idx(set_idx),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .out_valid(q_out_valid), .out_ready(out_ready),
        .hit(q_hit), .multi_hit(q_multi_hit), .hit_addr(q_hit_addr),
        .master(q_master), .prot(q_prot)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk_i);
        ram_we    = 1'b1;
        ram_waddr = a;
        ram_wdata = d;
        @(posedge clk_i);
        #1;
        ram_we = 1'b0;
        m_mem[a] = d;
    endtask

    // Reference: scan offsets in order; two ports per step, so a step is a pair of offsets
    task automatic model(input logic [31:0] a, input logic rw, input logic [4:0] s);
        int cnt, first, g, gcnt;
        logic [31:0] e;
        cnt = 0; first = -1;
        for (int o = 0; o < 16; o++) begin
            e = m_mem[{s, o[3:0]}];
            if (e[0] && e[23:4] == a[31:12]) begin
                cnt++;
                if (first < 0) first = o;
            end
        end
        e_hit = (cnt > 0) ? 1 : 0;
        e_multi = (cnt >= 2) ? 1 : 0;
        e_addr = (cnt > 0) ? s * 16 + first : 0;
        e = (cnt > 0) ? m_mem[{s, first[3:0]}] : 32'h0;
        e_master = (cnt > 0) ? int'(e[3]) : 0;
        e_prot = (cnt == 0) ? 0 : (rw ? int'(!e[2]) : int'(!e[1]));
        e_qhit = e_hit; e_qaddr = e_addr; e_qmaster = e_master; e_qprot = e_prot;
        if (cnt > 0) begin
            g = first / 2;
            gcnt = 0;
            for (int o = 2 * g; o < 2 * g + 2; o++) begin
                e = m_mem[{s, o[3:0]}];
                if (e[0] && e[23:4] == a[31:12]) gcnt++;
            end
            e_qmulti = (gcnt >= 2) ? 1 : 0;
            e_qlat = g + 3;
        end else begin
            e_qmulti = 0;
            e_qlat = 10;
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic rw, input logic [4:0] s);
        model(a, rw, s);
        @(negedge clk_i);
        in_addr = a; rw_type = rw; set_idx = s; start_valid = 1'b1;
        chk_val("start_ready_f", f_start_ready, 1);
        chk_val("start_ready_q", q_start_ready, 1);
        @(posedge clk_i);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic run_search(input logic [31:0] a, input logic rw, input logic [4:0] s);
        int lat_f, lat_q;
        accept(a, rw, s);
        lat_f = 0; lat_q = 0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            if (q_out_valid && lat_q == 0) lat_q = cyc;
            if (f_out_valid) begin
                lat_f = cyc;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        chk_val("lat_full", lat_f, 10);
        chk_val("lat_fast", lat_q, e_qlat);
        chk_val("hit_f", f_hit, e_hit);
        chk_val("multi_f", f_multi_hit, e_multi);
        chk_val("master_f", f_master, e_master);
        chk_val("prot_f", f_prot, e_prot);
        if (e_hit != 0) chk_val("addr_f", f_hit_addr, e_addr);
        chk_val("valid_q", q_out_valid, 1);
        chk_val("hit_q", q_hit, e_qhit);
        chk_val("multi_q", q_multi_hit, e_qmulti);
        chk_val("master_q", q_master, e_qmaster);
        chk_val("prot_q", q_prot, e_qprot);
        if (e_qhit != 0) chk_val("addr_q", q_hit_addr, e_qaddr);
    endtask

    task automatic release_result();
        @(negedge clk_i);
        out_ready = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready = 1'b0;
        chk_val("valid_after_rdy_f", f_out_valid, 0);
        chk_val("valid_after_rdy_q", q_out_valid, 0);
        chk_val("idle_ready_f", f_start_ready, 1);
    endtask

    task automatic clear_set(input logic [4:0] s);
        for (int o = 0; o < 16; o++) wr({s, o[3:0]}, 32'h0);
    endtask

    initial begin
        logic [19:0] vpn;
        logic [4:0]  s;
        logic [31:0] d;
        int dens;

        rst_ni = 1'b0; start_valid = 1'b0; in_addr = '0; rw_type = 1'b0;
        set_idx = '0; ram_we = 1'b0; ram_waddr = '0; ram_wdata = '0; out_ready = 1'b0;
        for (int i = 0; i < 512; i++) m_mem[i] = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_val("rst_valid", f_out_valid, 0);
        chk_val("rst_hit", f_hit, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk_val("rst_start_ready", f_start_ready, 1);
        chk_val("rst_valid_q", q_out_valid, 0);

        // Single matching entry, read access allowed
        clear_set(5'd3);
        wr({5'd3, 4'd5}, {8'h0, 20'h12345, 4'b0111});
        run_search(32'h12345ABC, 1'b0, 5'd3);
        chk_val("d1_addr", f_hit_addr, {5'd3, 4'd5});
        release_result();

        // Write without write permission
        wr({5'd3, 4'd5}, {8'h0, 20'h12345, 4'b0011});
        run_search(32'h12345ABC, 1'b1, 5'd3);
        chk_val("d2_prot", f_prot, 1);
        release_result();

        // Two matches at offsets 2 and 14
        clear_set(5'd3);
        wr({5'd3, 4'd2}, {8'h0, 20'h12345, 4'b1111});
        wr({5'd3, 4'd14}, {8'h0, 20'h12345, 4'b0111});
        run_search(32'h12345000, 1'b0, 5'd3);
        chk_val("d3_multi", f_multi_hit, 1);
        release_result();

        // Empty set, result held while out_ready stays low
        clear_set(5'd9);
        run_search(32'h0ABCD123, 1'b0, 5'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            chk_val("hold_valid", f_out_valid, 1);
            chk_val("hold_hit", f_hit, 0);
            chk_val("hold_prot", f_prot, 0);
            chk_val("hold_start_ready", f_start_ready, 0);
        end
        release_result();

        // Reset in the middle of a search
        accept(32'h12345000, 1'b0, 5'd3);
        repeat (4) begin
            @(posedge clk_i);
            #1;
        end
        rst_ni = 1'b0;
        #1;
        chk_val("midrst_valid_f", f_out_valid, 0);
        chk_val("midrst_valid_q", q_out_valid, 0);
        chk_val("midrst_hit", f_hit, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i);
            #1;
            chk_val("abandoned_valid", f_out_valid | q_out_valid, 0);
        end
        run_search(32'h12345000, 1'b0, 5'd3);
        release_result();

        // Randomized sets
        for (int it = 0; it < 24; it++) begin
            s = 5'($urandom_range(0, 31));
            vpn = 20'($urandom);
            dens = $urandom_range(0, 3);
            for (int o = 0; o < 16; o++) begin
                d = $urandom;
                if ($urandom_range(0, 7) < dens) d[23:4] = vpn;
                wr({s, o[3:0]}, d);
            end
            run_search({vpn, 12'($urandom)}, 1'($urandom), s);
            release_result();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/check_ram_nport.md
CHECK_RAM_NPORT -- requirements
Module: check_ram_nport

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: virtual address width.
REQ-002 SHALL have parameter PAGE_SIZE, default 4096: page size; IGNORE_LSB = log2(PAGE_SIZE); VPN_W = ADDR_WIDTH-IGNORE_LSB.
REQ-003 SHALL have parameter SET_WIDTH, default 5: set index width.
REQ-004 SHALL have parameter OFFSET_WIDTH, default 4: entries per set = 2^OFFSET_WIDTH; RAM address width AW = SET_WIDTH+OFFSET_WIDTH.
REQ-005 SHALL have parameter N_PORTS, default 2: read ports per cycle; power of two, 1..2^OFFSET_WIDTH; S = 2^OFFSET_WIDTH/N_PORTS scan steps.
REQ-006 SHALL have parameter MULTIHIT_CHECK, default 1: 1 = full scan with multi-hit detection; 0 = stop at first hit.
REQ-007 SHALL have ports: clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: start_valid in 1; start_ready out 1; in_addr in ADDR_WIDTH; rw_type in 1 (1 write, 0 read); set_idx in SET_WIDTH.
REQ-009 SHALL have ports: ram_we in 1; ram_waddr in AW; ram_wdata in 32.
REQ-010 SHALL have ports: out_valid out 1; out_ready in 1; hit out 1; multi_hit out 1; hit_addr out AW; master out 1; prot out 1.

Function
REQ-011 Entry format SHALL be bit0 valid, bit1 read-allowed, bit2 write-allowed, bit3 master, bits[4+VPN_W-1:4] VPN.
REQ-012 RAM SHALL be 2^AW x 32, one write port plus N_PORTS synchronous read ports, one-cycle read latency, read-first on same-address write.
REQ-013 Writes SHALL be accepted in any state; an in-progress search uses whatever data its reads return.
REQ-014 FSM states SHALL be IDLE, SEARCH, DRAIN, DONE; start_ready = 1 only in IDLE.
REQ-015 IDLE: on start_valid, SHALL latch in_addr, rw_type, set_idx, clear hit records, clear step counter k, go SEARCH.
REQ-016 SEARCH: port p SHALL read address {set_q, k*N_PORTS+p}; k increments each cycle; at k = S-1 go DRAIN.
REQ-017 Port p SHALL hit when its read data has valid = 1 and VPN equals in_addr_q[ADDR_WIDTH-1:IGNORE_LSB]; compare occurs the cycle after the read.
REQ-018 First hit SHALL be recorded as the lowest compare cycle, then lowest port index; saved fields are offset (hit_addr), master bit, and prot.
REQ-019 prot SHALL be (rw_type_q and not write-allowed) or (not rw_type_q and not read-allowed) of the recorded entry; 0 on miss.
REQ-020 Hit count SHALL saturate at 2 and include same-cycle multiple hits; multi_hit = (count = 2).
REQ-021 DRAIN SHALL perform the final compare and go DONE.
REQ-022 With MULTIHIT_CHECK = 0, the cycle a hit is compared SHALL go directly to DONE, ignoring remaining reads; multi_hit SHALL then reflect only same-cycle hits.
REQ-023 DONE: out_valid = 1 with stable hit/multi_hit/hit_addr/master/prot; on out_ready go IDLE.
REQ-024 Outside DONE, out_valid, hit, multi_hit, master, and prot SHALL be 0 and hit_addr SHALL be 0.
REQ-025 Full-scan latency SHALL be: out_valid high S+2 cycles after the accepting cycle, regardless of hit position.

Reset
REQ-026 rst_ni low SHALL immediately force IDLE, k = 0, cleared hit records, and all outputs 0 with start_ready = 1 after release; RAM contents SHALL be left unchanged.
REQ-027 Reset asserted mid-search SHALL abandon the search with no out_valid.

Verification
REQ-028 Defaults (S = 8): entry at set 3 offset 5 = VPN 0x12345, bits3..0 = 0111; start in_addr 0x12345ABC, rw_type 0 -> out_valid at cycle 10, hit = 1, hit_addr = {3,5}, master = 0, prot = 0, multi_hit = 0.
REQ-029 Same entry with bit2 = 0, rw_type 1 -> hit = 1, prot = 1.
REQ-030 Matching entries at offsets 2 and 14 -> hit_addr offset 2, multi_hit = 1; with MULTIHIT_CHECK = 0 -> out_valid at cycle 4, multi_hit = 0.
REQ-031 Empty set -> out_valid at cycle 10, hit = 0, prot = 0; hold out_ready = 0 for 5 cycles -> outputs stable, start_ready = 0.
REQ-032 Assert rst_ni low at cycle 5 of a search -> outputs 0 immediately; new search after release returns correct results.
